// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side hazard controller bus: stage register fields and memory handshake in,
// write enables, flush/bubble controls, forwarding selects and status out.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] ifid_rs_i;
    logic [REG_ADDR_W-1:0] ifid_rt_i;
    logic                  ifid_uses_rt_i;
    logic                  idex_memread_i;
    logic [REG_ADDR_W-1:0] idex_rs_i;
    logic [REG_ADDR_W-1:0] idex_rt_i;
    logic                  exmem_regwrite_i;
    logic [REG_ADDR_W-1:0] exmem_rd_i;
    logic                  memwb_regwrite_i;
    logic [REG_ADDR_W-1:0] memwb_rd_i;
    logic                  branch_taken_i;
    logic                  jump_i;
    logic                  mem_req_i;
    logic                  mem_ready_i;
    logic                  pc_write_o;
    logic                  ifid_write_o;
    logic                  idex_write_o;
    logic                  exmem_write_o;
    logic                  ifid_flush_o;
    logic                  idex_bubble_o;
    logic                  memwb_bubble_o;
    logic [1:0]            fwd_a_o;
    logic [1:0]            fwd_b_o;
    logic                  mem_timeout_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rs_i, idex_rt_i,
               exmem_regwrite_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i,
               branch_taken_i, jump_i, mem_req_i, mem_ready_i,
        input  pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, ifid_flush_o,
               idex_bubble_o, memwb_bubble_o, fwd_a_o, fwd_b_o, mem_timeout_o, stall_cnt_o
    );

    modport slave (
        input  ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rs_i, idex_rt_i,
               exmem_regwrite_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i,
               branch_taken_i, jump_i, mem_req_i, mem_ready_i,
        output pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, ifid_flush_o,
               idex_bubble_o, memwb_bubble_o, fwd_a_o, fwd_b_o, mem_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/stall/forwarding controller for a 5-stage pipeline: load-use bubbles,
// variable-latency data-memory freeze with timeout, operand forwarding and stall counter.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int CNT_W           = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [1:0]      LU_INIT   = 2'(LOAD_USE_STALLS - 1);

    typedef enum logic [1:0] {ST_RUN, ST_LU_STALL, ST_MEM_WAIT, ST_ERR} state_t;

    state_t            state_q, state_d, ret_q, ret_d, eff_state_s;
    logic [1:0]        lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              lu_haz_s, mem_stall_s;
    logic              pc_w_s, ifid_w_s, idex_w_s, exmem_w_s;
    logic              flush_s, idex_bub_s, memwb_bub_s;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  exmem_rw,
        input logic [REG_ADDR_W-1:0] exmem_rd,
        input logic                  memwb_rw,
        input logic [REG_ADDR_W-1:0] memwb_rd
    );
        logic [1:0] sel;
        if (exmem_rw && (exmem_rd != {REG_ADDR_W{1'b0}}) && (exmem_rd == src)) begin
            sel = 2'b10;
        end else if (memwb_rw && (memwb_rd != {REG_ADDR_W{1'b0}}) && (memwb_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign lu_haz_s = bus.idex_memread_i && (bus.idex_rt_i != {REG_ADDR_W{1'b0}}) &&
                      ((bus.idex_rt_i == bus.ifid_rs_i) ||
                       (bus.ifid_uses_rt_i && (bus.idex_rt_i == bus.ifid_rt_i)));
    assign mem_stall_s = bus.mem_req_i & ~bus.mem_ready_i;

    // A ready beat in MEM_WAIT releases the freeze this cycle, so act as the interrupted state.
    always_comb begin
        if ((state_q == ST_MEM_WAIT) && bus.mem_ready_i) begin
            eff_state_s = ret_q;
        end else begin
            eff_state_s = state_q;
        end
    end

    // Next-state and control decode; ERR outranks memory stall, which outranks load-use.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        lu_cnt_d    = lu_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        pc_w_s      = 1'b1;
        ifid_w_s    = 1'b1;
        idex_w_s    = 1'b1;
        exmem_w_s   = 1'b1;
        flush_s     = 1'b0;
        idex_bub_s  = 1'b0;
        memwb_bub_s = 1'b0;
        case (eff_state_s)
            ST_RUN: begin
                if (mem_stall_s) begin
                    {pc_w_s, ifid_w_s, idex_w_s, exmem_w_s} = 4'b0000;
                    memwb_bub_s = 1'b1;
                    ret_d       = ST_RUN;
                    wait_cnt_d  = WAIT_ONE;
                    state_d     = ST_MEM_WAIT;
                end else if (lu_haz_s) begin
                    pc_w_s     = 1'b0;
                    ifid_w_s   = 1'b0;
                    idex_bub_s = 1'b1;
                    if (LOAD_USE_STALLS > 1) begin
                        lu_cnt_d = LU_INIT;
                        state_d  = ST_LU_STALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    flush_s = bus.branch_taken_i | bus.jump_i;
                    state_d = ST_RUN;
                end
            end
            ST_LU_STALL: begin
                if (mem_stall_s) begin
                    {pc_w_s, ifid_w_s, idex_w_s, exmem_w_s} = 4'b0000;
                    memwb_bub_s = 1'b1;
                    ret_d       = ST_LU_STALL;
                    wait_cnt_d  = WAIT_ONE;
                    state_d     = ST_MEM_WAIT;
                end else begin
                    pc_w_s     = 1'b0;
                    ifid_w_s   = 1'b0;
                    idex_bub_s = 1'b1;
                    lu_cnt_d   = lu_cnt_q - 2'd1;
                    state_d    = (lu_cnt_q == 2'd1) ? ST_RUN : ST_LU_STALL;
                end
            end
            ST_MEM_WAIT: begin
                {pc_w_s, ifid_w_s, idex_w_s, exmem_w_s} = 4'b0000;
                memwb_bub_s = 1'b1;
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    state_d    = ST_MEM_WAIT;
                end
            end
            ST_ERR: begin
                {pc_w_s, ifid_w_s, idex_w_s, exmem_w_s} = 4'b0000;
                memwb_bub_s = 1'b1;
                state_d     = ST_ERR;
            end
            default: begin
                {pc_w_s, ifid_w_s, idex_w_s, exmem_w_s} = 4'b0000;
                memwb_bub_s = 1'b1;
                state_d     = ST_RUN;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_RUN;
            ret_q      <= ST_RUN;
            lu_cnt_q   <= 2'd0;
            wait_cnt_q <= {WAIT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else if (!pc_w_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    // Controls are forced inactive while reset is held.
    assign bus.pc_write_o     = rst_n_i & pc_w_s;
    assign bus.ifid_write_o   = rst_n_i & ifid_w_s;
    assign bus.idex_write_o   = rst_n_i & idex_w_s;
    assign bus.exmem_write_o  = rst_n_i & exmem_w_s;
    assign bus.ifid_flush_o   = rst_n_i & flush_s;
    assign bus.idex_bubble_o  = rst_n_i & idex_bub_s;
    assign bus.memwb_bubble_o = rst_n_i & memwb_bub_s;
    assign bus.fwd_a_o = {2{rst_n_i}} & fwd_sel(bus.idex_rs_i, bus.exmem_regwrite_i, bus.exmem_rd_i,
                                                 bus.memwb_regwrite_i, bus.memwb_rd_i);
    assign bus.fwd_b_o = {2{rst_n_i}} & fwd_sel(bus.idex_rt_i, bus.exmem_regwrite_i, bus.exmem_rd_i,
                                                 bus.memwb_regwrite_i, bus.memwb_rd_i);
    assign bus.mem_timeout_o  = (state_q == ST_ERR);
    assign bus.stall_cnt_o    = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench: three controller instances (1 bubble, 3 bubbles, timeout 4)
// share stimulus; each step pushes the expected output word and pops it against the DUT.
module tb_pipeline_hazard_ctrl;
    localparam int K_RST = 0, K_RUN = 1, K_BUB = 2, K_FRZ = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
    logic ifid_uses_rt, idex_memread, exmem_rw, memwb_rw, branch_taken, jump, mem_req, mem_ready;
    logic [27:0] obs_v [3];

    typedef struct {
        string       tag;
        int          d;
        logic [27:0] v;
    } exp_t;
    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();
        assign bus.ifid_rs_i        = ifid_rs;
        assign bus.ifid_rt_i        = ifid_rt;
        assign bus.ifid_uses_rt_i   = ifid_uses_rt;
        assign bus.idex_memread_i   = idex_memread;
        assign bus.idex_rs_i        = idex_rs;
        assign bus.idex_rt_i        = idex_rt;
        assign bus.exmem_regwrite_i = exmem_rw;
        assign bus.exmem_rd_i       = exmem_rd;
        assign bus.memwb_regwrite_i = memwb_rw;
        assign bus.memwb_rd_i       = memwb_rd;
        assign bus.branch_taken_i   = branch_taken;
        assign bus.jump_i           = jump;
        assign bus.mem_req_i        = mem_req;
        assign bus.mem_ready_i      = mem_ready;
        assign obs_v[g] = {bus.stall_cnt_o, bus.pc_write_o, bus.ifid_write_o, bus.idex_write_o,
                           bus.exmem_write_o, bus.ifid_flush_o, bus.idex_bubble_o,
                           bus.memwb_bubble_o, bus.fwd_a_o, bus.fwd_b_o, bus.mem_timeout_o};
        pipeline_hazard_ctrl #(
            .REG_ADDR_W(5),
            .LOAD_USE_STALLS((g == 1) ? 3 : 1),
            .MEM_TIMEOUT((g == 2) ? 4 : 255),
            .CNT_W(16)
        ) dut (
            .clk_i  (clk),
            .rst_n_i(rst_n),
            .bus    (bus.slave)
        );
    end

    // Expected output word: {stall_cnt, pc, ifid, idex, exmem, flush, idexb, memwbb, fa, fb, to}
    function automatic logic [27:0] ev(input int sc, input int kind, input logic fl,
                                       input logic [1:0] fa, input logic [1:0] fb, input logic to);
        logic [3:0] we;
        logic       ib, mb;
        we = 4'b0000; ib = 1'b0; mb = 1'b0;
        if (kind == K_RUN) we = 4'b1111;
        if (kind == K_BUB) begin we = 4'b0011; ib = 1'b1; end
        if (kind == K_FRZ) mb = 1'b1;
        return {16'(sc), we, fl, ib, mb, fa, fb, to};
    endfunction

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic idle();
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rs = 5'd0; idex_rt = 5'd0;
        exmem_rd = 5'd0; memwb_rd = 5'd0; ifid_uses_rt = 1'b0; idex_memread = 1'b0;
        exmem_rw = 1'b0; memwb_rw = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic chk(input int d, input string tag, input logic [27:0] e);
        exp_t x;
        exp_t y;
        x.tag = tag; x.d = d; x.v = e;
        sb.push_back(x);
        #2;
        while (sb.size() > 0) begin
            y = sb.pop_front();
            n_checks++;
            assert (obs_v[y.d] === y.v) else begin
                n_errors++;
                $error("FAIL %s: observed %h expected %h", y.tag, obs_v[y.d], y.v);
            end
        end
    endtask

    task automatic do_reset(input int d, input string tag);
        nx();
        rst_n = 1'b0;
        chk(d, tag, ev(0, K_RST, 1'b0, 2'b00, 2'b00, 1'b0));
        nx();
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        exmem_rw = 1'b1; exmem_rd = 5'd5; idex_rs = 5'd5;
        idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        nx();
        chk(0, "reset", ev(0, K_RST, 1'b0, 2'b00, 2'b00, 1'b0));
        nx(); idle(); rst_n = 1'b1;

        // Load-use with a single bubble
        nx(); idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        chk(0, "lu1_bub", ev(0, K_BUB, 1'b0, 2'b00, 2'b00, 1'b0));
        nx(); idex_memread = 1'b0;
        chk(0, "lu1_run", ev(1, K_RUN, 1'b0, 2'b00, 2'b00, 1'b0));
        nx(); idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        chk(0, "lu1_rt0", ev(1, K_RUN, 1'b0, 2'b00, 2'b00, 1'b0));
        nx(); idex_rt = 5'd7; ifid_rt = 5'd7; ifid_uses_rt = 1'b1; ifid_rs = 5'd3;
        chk(0, "lu1_rt_bub", ev(1, K_BUB, 1'b0, 2'b00, 2'b00, 1'b0));
        nx(); ifid_uses_rt = 1'b0;
        chk(0, "lu1_no_rt", ev(2, K_RUN, 1'b0, 2'b00, 2'b00, 1'b0));

        // Three bubbles, branch flush held off until back in RUN
        do_reset(1, "rst_b");
        nx(); idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; branch_taken = 1'b1;
        chk(1, "lu3_b0", ev(0, K_BUB, 1'b0, 2'b00, 2'b00, 1'b0));
        nx(); idex_memread = 1'b0;
        chk(1, "lu3_b1", ev(1, K_BUB, 1'b0, 2'b00, 2'b00, 1'b0));
        nx();
        chk(1, "lu3_b2", ev(2, K_BUB, 1'b0, 2'b00, 2'b00, 1'b0));
        nx();
        chk(1, "lu3_flush", ev(3, K_RUN, 1'b1, 2'b00, 2'b00, 1'b0));
        nx(); branch_taken = 1'b0; jump = 1'b1;
        chk(1, "lu3_jump", ev(3, K_RUN, 1'b1, 2'b00, 2'b00, 1'b0));
        nx(); jump = 1'b0;
        chk(1, "lu3_run", ev(3, K_RUN, 1'b0, 2'b00, 2'b00, 1'b0));

        // Five-cycle memory wait released in the ready cycle
        do_reset(0, "rst_c");
        for (int i = 0; i < 5; i++) begin
            nx(); mem_req = 1'b1; mem_ready = 1'b0;
            chk(0, $sformatf("mw_frz%0d", i), ev(i, K_FRZ, 1'b0, 2'b00, 2'b00, 1'b0));
        end
        nx(); mem_ready = 1'b1;
        chk(0, "mw_ready", ev(5, K_RUN, 1'b0, 2'b00, 2'b00, 1'b0));
        nx();
        chk(0, "mw_zero_wait", ev(5, K_RUN, 1'b0, 2'b00, 2'b00, 1'b0));

        // Memory stall interrupting the load-use stall
        do_reset(1, "rst_d");
        nx(); idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        chk(1, "lum_b0", ev(0, K_BUB, 1'b0, 2'b00, 2'b00, 1'b0));
        nx(); idex_memread = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
        chk(1, "lum_f0", ev(1, K_FRZ, 1'b0, 2'b00, 2'b00, 1'b0));
        nx();
        chk(1, "lum_f1", ev(2, K_FRZ, 1'b0, 2'b00, 2'b00, 1'b0));
        nx(); mem_ready = 1'b1;
        chk(1, "lum_b1", ev(3, K_BUB, 1'b0, 2'b00, 2'b00, 1'b0));
        nx(); mem_req = 1'b0; mem_ready = 1'b0;
        chk(1, "lum_b2", ev(4, K_BUB, 1'b0, 2'b00, 2'b00, 1'b0));
        nx();
        chk(1, "lum_run", ev(5, K_RUN, 1'b0, 2'b00, 2'b00, 1'b0));

        // Timeout into ERR, sticky until reset
        do_reset(2, "rst_e");
        for (int i = 0; i < 4; i++) begin
            nx(); mem_req = 1'b1; mem_ready = 1'b0;
            chk(2, $sformatf("to_frz%0d", i), ev(i, K_FRZ, 1'b0, 2'b00, 2'b00, 1'b0));
        end
        nx();
        chk(2, "to_err", ev(4, K_FRZ, 1'b0, 2'b00, 2'b00, 1'b1));
        nx(); mem_ready = 1'b1;
        chk(2, "to_sticky", ev(5, K_FRZ, 1'b0, 2'b00, 2'b00, 1'b1));
        do_reset(2, "to_rst");
        nx();
        chk(2, "to_after_rst", ev(0, K_RUN, 1'b0, 2'b00, 2'b00, 1'b0));

        // Forwarding selects
        nx(); exmem_rw = 1'b1; memwb_rw = 1'b1; exmem_rd = 5'd5; memwb_rd = 5'd5; idex_rs = 5'd5;
        chk(0, "fwd_a_ex", ev(0, K_RUN, 1'b0, 2'b10, 2'b00, 1'b0));
        nx(); exmem_rw = 1'b0;
        chk(0, "fwd_a_wb", ev(0, K_RUN, 1'b0, 2'b01, 2'b00, 1'b0));
        nx(); exmem_rw = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0; idex_rs = 5'd0;
        chk(0, "fwd_a_r0", ev(0, K_RUN, 1'b0, 2'b00, 2'b00, 1'b0));
        nx(); exmem_rd = 5'd9; memwb_rd = 5'd9; idex_rt = 5'd9; idex_rs = 5'd2;
        chk(0, "fwd_b_ex", ev(0, K_RUN, 1'b0, 2'b00, 2'b10, 1'b0));
        nx(); exmem_rw = 1'b0;
        chk(0, "fwd_b_wb", ev(0, K_RUN, 1'b0, 2'b00, 2'b01, 1'b0));
        nx(); exmem_rw = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0; idex_rt = 5'd0;
        chk(0, "fwd_b_r0", ev(0, K_RUN, 1'b0, 2'b00, 2'b00, 1'b0));
        nx(); exmem_rd = 5'd4; memwb_rd = 5'd6; idex_rs = 5'd6; idex_rt = 5'd4;
        chk(0, "fwd_mix", ev(0, K_RUN, 1'b0, 2'b01, 2'b10, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
